pstack: RTL and testbench
=========================

# pstack

Parametrised register stack for the tinycpu datapath: the successor to the fixed 16-bit operand stack. Adds configurable width and depth, an occupancy count, full/empty status, sticky overflow/underflow error flags, a combined push+pop (replace-top) operation and a swap of the top two entries. It feeds the ALU directly through `qtop`/`qnext` and is driven by the control unit's one-hot-ish stack command lines.

## Interface
- `WIDTH`, 16, data width of each entry
- `DEPTH`, 8, number of entries; legal range 2..256
- `CW`, $clog2(DEPTH+1), width of `count` (derived, not overridden)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `push`  in  1  push `d` onto the stack
- `pop`  in  1  discard top entry
- `load`  in  1  overwrite top entry with `d`
- `swap`  in  1  exchange top two entries
- `clr_err`  in  1  synchronous clear of `ovf`/`unf`
- `d`  in  WIDTH  write data
- `qtop`  out  WIDTH  entry 0 (top); 0 when empty
- `qnext`  out  WIDTH  entry 1; 0 when count < 2
- `count`  out  CW  number of valid entries, 0..DEPTH
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `ovf`  out  1  sticky overflow flag
- `unf`  out  1  sticky underflow flag

## Operation
- Storage is a shift register s[0..DEPTH-1], s[0] = top. `qtop` = s[0], `qnext` = s[1], driven straight from flops. Invalid entries are always 0.
- Reset (`reset` low, async): all s[i] = 0, `count` = 0, `ovf` = `unf` = 0. So `qtop` = `qnext` = 0, `empty` = 1, `full` = 0.
- One operation per cycle. Priority, highest first:
  - push&pop: replace top. s[0] = d, count unchanged. If empty, acts as push (count 0 -> 1).
  - push: s[i+1] = s[i], s[0] = d, count+1. At full, s[DEPTH-1] is discarded, count stays DEPTH, `ovf` set.
  - pop: s[i] = s[i+1], s[DEPTH-1] = 0, count-1. When empty: no state change, `unf` set.
  - swap: s[0] <-> s[1]. When count < 2: no state change, `unf` set.
  - load: s[0] = d. When empty, count becomes 1.
- Any command lower in the list is ignored when a higher one is asserted in the same cycle.
- `ovf`/`unf` are sticky until `clr_err` or reset.
  - If `clr_err` and a new error occur in the same cycle, the new error wins and the flag stays 1.
  - `clr_err` does not affect stack contents.
- `empty`/`full` are combinational decodes of the `count` register.
- `count` never exceeds DEPTH and never wraps below 0.

## Timing
- All state updates on the rising `clk` edge. Results of an operation are visible on `qtop`/`qnext`/`count`/flags one cycle later, i.e. immediately after that edge.
- No handshake: commands are sampled every edge, and the caller may issue back-to-back operations every cycle.
- `d` must be stable with the command at the sampling edge.
- Asserting `reset` at any time, including mid-sequence, forces the reset state without waiting for `clk`.
- Deassertion is sampled at the next edge: the first operation takes effect at the first rising edge with `reset` high.
- Idle cycle (no command): all state holds.

## Test plan
Run with WIDTH=16, DEPTH=4.
- Reset, then push 1111, 2222, 3333 on consecutive edges -> qtop=3333, qnext=2222, count=3, empty=0, full=0.
- Push 4444 then 5555 -> after 4444: full=1, count=4. After 5555: qtop=5555, qnext=4444, count=4, ovf=1, and 1111 is lost. Next, pop ×4 -> qtop sequence 4444, 3333, 2222, 0; count ends at 0, empty=1.
- From empty: pop -> unf=1, count=0, qtop=0. Swap with one entry (after push AAAA) -> unf stays 1, qtop=AAAA. Then clr_err -> unf=0.
- With stack 1111/2222: push&pop with d=1234 -> qtop=1234, qnext=1111, count=2. Then load d=5678 -> qtop=5678, count=2. Then swap -> qtop=1111, qnext=5678.
- From empty: load d=BEEF -> count=1, qtop=BEEF. Push with load also high, d=CAFE -> qtop=CAFE, qnext=BEEF (load ignored).
- Push 3 entries, then drop `reset` between edges -> outputs go to 0 and count to 0 before the next edge. After release, push 0001 -> count=1, qtop=0001, qnext=0.

Source files
------------

// File: rtl/pstack.sv
// Parametrised operand stack for the tinycpu datapath: shift-register storage with
// occupancy count, full/empty decode, sticky overflow/underflow and replace/swap ops.
module pstack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_load,
  input  logic                         i_swap,
  input  logic                         i_clr_err,
  input  logic [WIDTH-1:0]             i_d,
  output logic [WIDTH-1:0]             o_qtop,
  output logic [WIDTH-1:0]             o_qnext,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_ovf,
  output logic                         o_unf
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_s [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic w_empty;
  logic w_full;
  logic w_ovfEvt;
  logic w_unfEvt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);

  // Error events follow the command priority: push&pop never errors, pop shadows swap.
  assign w_ovfEvt = i_push & ~i_pop & w_full;
  assign w_unfEvt = ~i_push & ((i_pop & w_empty) | (~i_pop & i_swap & (r_count < CNT_TWO)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_s[i] <= '0;
      r_count <= '0;
    end else if (i_push && i_pop) begin
      r_s[0] <= i_d;
      if (w_empty) r_count <= CNT_ONE;
    end else if (i_push) begin
      r_s[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_s[i] <= r_s[i-1];
      if (!w_full) r_count <= r_count + CNT_ONE;
    end else if (i_pop) begin
      // Shifting in zero keeps every invalid slot cleared.
      if (!w_empty) begin
        for (int i = 0; i < DEPTH-1; i++) r_s[i] <= r_s[i+1];
        r_s[DEPTH-1] <= '0;
        r_count      <= r_count - CNT_ONE;
      end
    end else if (i_swap) begin
      if (r_count >= CNT_TWO) begin
        r_s[0] <= r_s[1];
        r_s[1] <= r_s[0];
      end
    end else if (i_load) begin
      r_s[0] <= i_d;
      if (w_empty) r_count <= CNT_ONE;
    end
  end

  // A fresh error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovfEvt | (r_ovf & ~i_clr_err);
      r_unf <= w_unfEvt | (r_unf & ~i_clr_err);
    end
  end

  assign o_qtop  = r_s[0];
  assign o_qnext = r_s[1];
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

endmodule

// File: tb/tb_pstack.sv
// Self-checking bench for pstack (WIDTH=16, DEPTH=4): directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_pstack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             push = 1'b0, pop = 1'b0, load = 1'b0, swap = 1'b0, clrErr = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic [WIDTH-1:0] qtop, qnext;
  logic [CW-1:0]    count;
  logic             empty, full, ovf, unf;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: queue with element 0 as top, plus sticky flags.
  logic [WIDTH-1:0] model[$];
  bit               mOvf, mUnf;

  pstack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_push(push), .i_pop(pop), .i_load(load),
    .i_swap(swap), .i_clr_err(clrErr), .i_d(d), .o_qtop(qtop), .o_qnext(qnext),
    .o_count(count), .o_empty(empty), .o_full(full), .o_ovf(ovf), .o_unf(unf)
  );

  always #5 clk = ~clk;

  // Apply one command in the queue model using the stated priority rules.
  task automatic modelStep(input bit p, input bit po, input bit l, input bit s,
                           input bit c, input logic [WIDTH-1:0] dv);
    bit newO = 0, newU = 0;
    logic [WIDTH-1:0] tmp;
    if (p && po) begin
      if (model.size() == 0) model.push_front(dv); else model[0] = dv;
    end else if (p) begin
      model.push_front(dv);
      if (model.size() > DEPTH) begin model.delete(DEPTH); newO = 1; end
    end else if (po) begin
      if (model.size() == 0) newU = 1; else model.delete(0);
    end else if (s) begin
      if (model.size() < 2) newU = 1;
      else begin tmp = model[0]; model[0] = model[1]; model[1] = tmp; end
    end else if (l) begin
      if (model.size() == 0) model.push_front(dv); else model[0] = dv;
    end
    mOvf = newO | (mOvf & ~c);
    mUnf = newU | (mUnf & ~c);
  endtask

  task automatic applyStimulus(input bit p, input bit po, input bit l, input bit s,
                               input bit c, input logic [WIDTH-1:0] dv);
    push = p; pop = po; load = l; swap = s; clrErr = c; d = dv;
    modelStep(p, po, l, s, c, dv);
    @(posedge clk);
    #1;
    push = 0; pop = 0; load = 0; swap = 0; clrErr = 0;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    #3;
    rstN = 1'b1;
    model.delete();
    mOvf = 0;
    mUnf = 0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #7;
    nChecks++;
    if ({qtop, qnext, count, empty, full, ovf, unf} !== {16'h0, 16'h0, 3'd0, 4'b1000}) begin
      nFails++;
      $display("[TB] FAIL reset_state got %h/%h cnt=%0d e=%b f=%b o=%b u=%b exp 0/0 cnt=0 e=1 f=0 o=0 u=0",
               qtop, qnext, count, empty, full, ovf, unf);
    end
    @(posedge clk); #1;
    doReset();
  endtask

  task automatic test_push_overflow();
    applyStimulus(1, 0, 0, 0, 0, 16'h1111);
    applyStimulus(1, 0, 0, 0, 0, 16'h2222);
    applyStimulus(1, 0, 0, 0, 0, 16'h3333);
    nChecks++;
    if ({qtop, qnext, count, empty, full} !== {16'h3333, 16'h2222, 3'd3, 2'b00}) begin
      nFails++;
      $display("[TB] FAIL push3 got %h/%h cnt=%0d e=%b f=%b exp 3333/2222 cnt=3 e=0 f=0",
               qtop, qnext, count, empty, full);
    end
    applyStimulus(1, 0, 0, 0, 0, 16'h4444);
    nChecks++;
    if ({full, count, ovf} !== {1'b1, 3'd4, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL push_to_full got f=%b cnt=%0d o=%b exp f=1 cnt=4 o=0", full, count, ovf);
    end
    applyStimulus(1, 0, 0, 0, 0, 16'h5555);
    nChecks++;
    if ({qtop, qnext, count, ovf, full} !== {16'h5555, 16'h4444, 3'd4, 2'b11}) begin
      nFails++;
      $display("[TB] FAIL push_overflow got %h/%h cnt=%0d o=%b f=%b exp 5555/4444 cnt=4 o=1 f=1",
               qtop, qnext, count, ovf, full);
    end
    begin
      logic [WIDTH-1:0] expTop [4];
      expTop = '{16'h4444, 16'h3333, 16'h2222, 16'h0000};
      for (int i = 0; i < 4; i++) begin
        applyStimulus(0, 1, 0, 0, 0, 16'h0);
        nChecks++;
        if (qtop !== expTop[i] || count !== CW'(3 - i)) begin
          nFails++;
          $display("[TB] FAIL pop_seq%0d got qtop=%h cnt=%0d exp qtop=%h cnt=%0d",
                   i, qtop, count, expTop[i], 3 - i);
        end
      end
    end
    nChecks++;
    if (empty !== 1'b1 || qnext !== 16'h0) begin
      nFails++;
      $display("[TB] FAIL pop_to_empty got e=%b qnext=%h exp e=1 qnext=0000", empty, qnext);
    end
  endtask

  task automatic test_underflow();
    applyStimulus(0, 1, 0, 0, 0, 16'h0);
    nChecks++;
    if ({unf, count, qtop} !== {1'b1, 3'd0, 16'h0}) begin
      nFails++;
      $display("[TB] FAIL pop_empty got u=%b cnt=%0d qtop=%h exp u=1 cnt=0 qtop=0000", unf, count, qtop);
    end
    applyStimulus(1, 0, 0, 0, 0, 16'hAAAA);
    applyStimulus(0, 0, 0, 1, 0, 16'h0);
    nChecks++;
    if ({unf, qtop, count} !== {1'b1, 16'hAAAA, 3'd1}) begin
      nFails++;
      $display("[TB] FAIL swap_one got u=%b qtop=%h cnt=%0d exp u=1 qtop=aaaa cnt=1", unf, qtop, count);
    end
    applyStimulus(0, 0, 0, 0, 1, 16'h0);
    nChecks++;
    if ({unf, ovf, qtop} !== {2'b00, 16'hAAAA}) begin
      nFails++;
      $display("[TB] FAIL clr_err got u=%b o=%b qtop=%h exp u=0 o=0 qtop=aaaa", unf, ovf, qtop);
    end
    // Clear and a new underflow together: the new error wins.
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 16'h0);
    applyStimulus(0, 1, 0, 0, 1, 16'h0);
    nChecks++;
    if (unf !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL clr_vs_new_err got u=%b exp u=1", unf);
    end
  endtask

  task automatic test_replace_load_swap();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 16'h1111);
    applyStimulus(1, 0, 0, 0, 0, 16'h2222);
    applyStimulus(1, 1, 0, 0, 0, 16'h1234);
    nChecks++;
    if ({qtop, qnext, count} !== {16'h1234, 16'h1111, 3'd2}) begin
      nFails++;
      $display("[TB] FAIL push_pop got %h/%h cnt=%0d exp 1234/1111 cnt=2", qtop, qnext, count);
    end
    applyStimulus(0, 0, 1, 0, 0, 16'h5678);
    nChecks++;
    if ({qtop, qnext, count} !== {16'h5678, 16'h1111, 3'd2}) begin
      nFails++;
      $display("[TB] FAIL load got %h/%h cnt=%0d exp 5678/1111 cnt=2", qtop, qnext, count);
    end
    applyStimulus(0, 0, 0, 1, 0, 16'h0);
    nChecks++;
    if ({qtop, qnext, unf} !== {16'h1111, 16'h5678, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL swap got %h/%h u=%b exp 1111/5678 u=0", qtop, qnext, unf);
    end
  endtask

  task automatic test_load_empty_priority();
    doReset();
    applyStimulus(0, 0, 1, 0, 0, 16'hBEEF);
    nChecks++;
    if ({count, qtop, qnext} !== {3'd1, 16'hBEEF, 16'h0}) begin
      nFails++;
      $display("[TB] FAIL load_empty got cnt=%0d %h/%h exp cnt=1 beef/0000", count, qtop, qnext);
    end
    applyStimulus(1, 0, 1, 0, 0, 16'hCAFE);
    nChecks++;
    if ({qtop, qnext, count} !== {16'hCAFE, 16'hBEEF, 3'd2}) begin
      nFails++;
      $display("[TB] FAIL push_over_load got %h/%h cnt=%0d exp cafe/beef cnt=2", qtop, qnext, count);
    end
    applyStimulus(1, 1, 0, 0, 0, 16'h7777);
    nChecks++;
    if ({qtop, qnext, count} !== {16'h7777, 16'hBEEF, 3'd2}) begin
      nFails++;
      $display("[TB] FAIL replace_top got %h/%h cnt=%0d exp 7777/beef cnt=2", qtop, qnext, count);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 16'h0A0A);
    applyStimulus(1, 0, 0, 0, 0, 16'h0B0B);
    applyStimulus(1, 0, 0, 0, 0, 16'h0C0C);
    #2;
    rstN = 1'b0;
    #1;
    nChecks++;
    if ({qtop, qnext, count, empty} !== {16'h0, 16'h0, 3'd0, 1'b1}) begin
      nFails++;
      $display("[TB] FAIL async_reset got %h/%h cnt=%0d e=%b exp 0000/0000 cnt=0 e=1",
               qtop, qnext, count, empty);
    end
    #1;
    rstN = 1'b1;
    model.delete();
    mOvf = 0;
    mUnf = 0;
    applyStimulus(1, 0, 0, 0, 0, 16'h0001);
    nChecks++;
    if ({count, qtop, qnext} !== {3'd1, 16'h0001, 16'h0}) begin
      nFails++;
      $display("[TB] FAIL after_release got cnt=%0d %h/%h exp cnt=1 0001/0000", count, qtop, qnext);
    end
  endtask

  task automatic test_random();
    logic [38:0]      expVec;
    logic [WIDTH-1:0] eTop, eNext;
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
                    $urandom_range(0, 9) < 1, WIDTH'($urandom));
      eTop  = (model.size() > 0) ? model[0] : '0;
      eNext = (model.size() > 1) ? model[1] : '0;
      expVec = {eTop, eNext, CW'(model.size()), model.size() == 0, model.size() == DEPTH, mOvf, mUnf};
      nChecks++;
      if ({qtop, qnext, count, empty, full, ovf, unf} !== expVec) begin
        nFails++;
        $display("[TB] FAIL random_step%0d got %h exp %h", i,
                 {qtop, qnext, count, empty, full, ovf, unf}, expVec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_overflow();
    test_underflow();
    test_replace_load_swap();
    test_load_empty_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
